l3_banked_tcdm_mem: RTL and testbench
=====================================

Name: l3_banked_tcdm_mem

Overview:
- Parametrised multi-port, word-interleaved banked on-chip memory with a TCDM-style request/grant/valid interface.
- Generalises the fixed 4-port, 32-bit, 1-cycle L3 subsystem with configurable data width, base address, bank count and read latency.
- Adds per-bank round-robin arbitration, out-of-range error responses and a saturating bank-conflict counter.
- Sits behind the AXI-to-TCDM bridge in the host domain.

Parameters:
- NumPorts, 4, number of TCDM master ports.
- NumBanks, 4, number of banks; power of two, >=2.
- BankWords, 1024, words per bank; power of two.
- DataWidth, 32, word width; multiple of 8, power of two.
- AddrWidth, 32, byte address width.
- BaseAddr, 32'h8000_0000, first byte address of the region.
- MemLatency, 1, cycles from grant to vld_o; >=1.
- WriteResp, 1, 1: writes also produce vld_o; 0: only reads do.
- Derived: BeWidth=DataWidth/8; OffW=log2(BeWidth); BankSel=log2(NumBanks); RowW=log2(BankWords).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NumPorts  request per port.
- add_i  in  NumPorts x AddrWidth  byte address.
- wen_i  in  NumPorts  1=read, 0=write.
- wdata_i  in  NumPorts x DataWidth  write data.
- be_i  in  NumPorts x BeWidth  byte enables.
- gnt_o  out  NumPorts  grant, combinational, same cycle as req_i.
- vld_o  out  NumPorts  response valid.
- rdata_o  out  NumPorts x DataWidth  read data, qualified by vld_o.
- err_o  out  NumPorts  out-of-range flag, qualified by vld_o.
- conflict_cnt_o  out  32  saturating count of lost-arbitration cycles.

Behaviour:
- Address decode:
  - off = add_i - BaseAddr.
  - bank = off[OffW +: BankSel].
  - row = off[OffW+BankSel +: RowW].
  - Low OffW bits are ignored.
- Out of range: add_i < BaseAddr, or off >= NumBanks*BankWords*BeWidth.
  - Granted unconditionally in the request cycle.
  - No bank access, no write.
  - vld_o after MemLatency cycles with err_o=1 and rdata_o=0, for reads and writes regardless of WriteResp.
- Arbitration, per bank:
  - Round-robin among in-range requesting ports.
  - The pointer moves to winner+1 (mod NumPorts) only on grant.
  - Losers see gnt_o=0 and must hold the request; request stability is not checked.
  - Ports targeting different banks are all granted in the same cycle.
- Bank access: on grant the bank is accessed at the next clk edge.
  - Write: only bytes with be_i=1 are updated.
  - Read: returns the pre-write contents when a read and a write to the same row occur in the same cycle; impossible, since one grant per bank per cycle.
  - A read granted the cycle after a write to the same row returns the new data.
- Response pipeline: per port, a MemLatency-deep shift register of {valid, err, is_read, bank}.
  - Read data is registered at stage 1 and delayed to stage MemLatency.
  - vld_o, rdata_o and err_o are registered outputs.
  - Responses are in order, one per port per cycle max; back-to-back grants give back-to-back vld_o.
  - Write with WriteResp=0: no vld_o.
  - Write responses carry rdata_o=0.
- conflict_cnt_o: add the number of in-range requesting ports with gnt_o=0 each cycle; saturates at 2^32-1, no wrap.
- Reset (rst_i=1 at an edge):
  - vld_o=0, err_o=0, rdata_o=0, conflict_cnt_o=0.
  - All pipeline valids cleared; all RR pointers=0.
  - In-flight responses are dropped.
  - Memory contents are not reset.
  - gnt_o=0 while rst_i=1.
- Memory is behavioural per-bank arrays in simulation; the ASIC build substitutes the technology SRAM macro. Bank read latency is fixed at 1; extra MemLatency stages are registers.

Test Plan:
- Single write/read, defaults: port0 writes 0xDEADBEEF to 0x8000_0010, be=4'hF; then reads it. Required: gnt same cycle; read vld_o 1 cycle after grant; rdata=0xDEADBEEF; err=0. Address maps to bank 0, row 1.
- Byte enables: write 0x11223344 to 0x8000_0004, then write 0xAABBCCDD with be=4'b0101 to the same address. Required: read returns 0x11BB33DD.
- Conflict: ports 0–3 all read bank 2 (0x8000_0008, 0x8000_0018, 0x8000_0028, 0x8000_0038) and hold req. Required: grants 0,1,2,3 in consecutive cycles; conflict_cnt_o = 3+2+1 = 6 at the end. Ports 0–3 reading banks 0–3 in parallel: all granted in one cycle, counter unchanged.
- Out of range: port1 writes to 0x7FFF_FFFC, then 0x8000_4000 (default size = 16 KiB). Required: immediate gnt; vld_o with err_o=1 and rdata=0; memory unchanged, checked by reading row 0 of bank 0.
- Latency/WriteResp sweep, MemLatency=3, WriteResp=0: 4 back-to-back reads on port2. Required: vld_o high on 4 consecutive cycles starting 3 cycles after the first grant, with correct data. Writes produce no vld_o.
- Reset mid-operation: assert rst_i one cycle after a read grant with MemLatency=3. Required: no vld_o for the dropped read; conflict_cnt_o=0. A subsequent read returns the data written before reset.

Source files
------------

// File: rtl/l3_banked_tcdm_mem.sv
// l3_banked_tcdm_mem: multi-port, word-interleaved banked on-chip memory with a
// TCDM request/grant/valid interface, per-bank round-robin arbitration,
// out-of-range error responses and a saturating bank-conflict counter.
//
// Handshake: a port's request (req_i with add_i/wen_i/wdata_i/be_i) is accepted
// in the cycle where gnt_o is high for that port (gnt_o is combinational on
// req_i). A port that sees gnt_o=0 must keep req_i and its fields stable until
// granted. Each accepted request yields at most one response, in order, on
// vld_o exactly MemLatency cycles later; vld_o has no back-pressure.
module l3_banked_tcdm_mem #(
    parameter int unsigned          NumPorts   = 4,
    parameter int unsigned          NumBanks   = 4,
    parameter int unsigned          BankWords  = 1024,
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          AddrWidth  = 32,
    parameter logic [AddrWidth-1:0] BaseAddr   = 32'h8000_0000,
    parameter int unsigned          MemLatency = 1,
    parameter bit                   WriteResp  = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPorts-1:0]               req_i,
    input  logic [NumPorts*AddrWidth-1:0]     add_i,
    input  logic [NumPorts-1:0]               wen_i,
    input  logic [NumPorts*DataWidth-1:0]     wdata_i,
    input  logic [NumPorts*(DataWidth/8)-1:0] be_i,
    output logic [NumPorts-1:0]               gnt_o,
    output logic [NumPorts-1:0]               vld_o,
    output logic [NumPorts*DataWidth-1:0]     rdata_o,
    output logic [NumPorts-1:0]               err_o,
    output logic [31:0]                       conflict_cnt_o
);

    localparam int unsigned BeWidth     = DataWidth / 8;
    localparam int unsigned OffW        = $clog2(BeWidth);
    localparam int unsigned BankSel     = $clog2(NumBanks);
    localparam int unsigned RowW        = $clog2(BankWords);
    localparam int unsigned PortW       = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned CntW        = $clog2(NumPorts + 1);
    localparam logic [63:0] RegionBytes = 64'(NumBanks) * 64'(BankWords) * 64'(BeWidth);

    // Per-port address decode
    logic [AddrWidth-1:0] port_off  [NumPorts];
    logic [BankSel-1:0]   port_bank [NumPorts];
    logic [RowW-1:0]      port_row  [NumPorts];
    logic [NumPorts-1:0]  port_inr;

    // Per-bank arbitration results
    logic [PortW-1:0]     rr_ptr   [NumBanks];
    logic [PortW-1:0]     win_port [NumBanks];
    logic [NumBanks-1:0]  win_any;
    logic [NumPorts-1:0]  bank_gnt;

    // Per-bank access fields, taken from the winning port
    logic [RowW-1:0]      bank_row   [NumBanks];
    logic [NumBanks-1:0]  bank_wr;
    logic [DataWidth-1:0] bank_wdata [NumBanks];
    logic [BeWidth-1:0]   bank_be    [NumBanks];
    logic [DataWidth-1:0] bank_rdata [NumBanks];
    logic [DataWidth-1:0] mem        [NumBanks][BankWords];

    // First response stage, loaded on the grant edge
    logic [NumPorts-1:0]  s0_vld;
    logic [NumPorts-1:0]  s0_err;
    logic [NumPorts-1:0]  s0_rd;
    logic [BankSel-1:0]   s0_bank  [NumPorts];
    logic [DataWidth-1:0] st0_data [NumPorts];

    logic [NumPorts-1:0]  lose_vec;
    logic [CntW-1:0]      lose_cnt;
    logic [32:0]          cnt_sum;

    // Decode offset, bank, row and range for every port
    always_comb begin
        for (int p = 0; p < int'(NumPorts); p++) begin
            port_off[p]  = add_i[p*AddrWidth +: AddrWidth] - BaseAddr;
            port_bank[p] = port_off[p][OffW +: BankSel];
            port_row[p]  = port_off[p][OffW+BankSel +: RowW];
            port_inr[p]  = (add_i[p*AddrWidth +: AddrWidth] >= BaseAddr) &&
                           (64'(port_off[p]) < RegionBytes);
        end
    end

    // Round-robin pick per bank, searching upward from the bank's pointer
    always_comb begin
        int   idx;
        int   win;
        logic found;
        idx      = 0;
        win      = 0;
        found    = 1'b0;
        bank_gnt = '0;
        win_any  = '0;
        for (int b = 0; b < int'(NumBanks); b++) begin
            found = 1'b0;
            win   = 0;
            for (int i = 0; i < int'(NumPorts); i++) begin
                idx = (int'(rr_ptr[b]) + i) % int'(NumPorts);
                if (!found && req_i[idx] && port_inr[idx] && (port_bank[idx] == BankSel'(b))) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            win_any[b]  = found;
            win_port[b] = PortW'(win);
            if (found) begin
                bank_gnt[win] = 1'b1;
            end
        end
    end

    // Out-of-range requests never touch a bank, so they are always granted
    assign gnt_o    = rst_i ? '0 : (bank_gnt | (req_i & ~port_inr));
    assign lose_vec = req_i & port_inr & ~gnt_o;

    // Route the winning port's access fields to each bank
    always_comb begin
        for (int b = 0; b < int'(NumBanks); b++) begin
            bank_row[b]   = port_row[win_port[b]];
            bank_wr[b]    = ~wen_i[win_port[b]];
            bank_wdata[b] = wdata_i[int'(win_port[b])*DataWidth +: DataWidth];
            bank_be[b]    = be_i[int'(win_port[b])*BeWidth +: BeWidth];
        end
    end

    // Bank arrays: byte-masked write or one-cycle registered read; contents survive reset
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < int'(NumBanks); b++) begin
            if (win_any[b] && !rst_i) begin
                if (bank_wr[b]) begin
                    for (int j = 0; j < int'(BeWidth); j++) begin
                        if (bank_be[b][j]) begin
                            mem[b][bank_row[b]][j*8 +: 8] <= bank_wdata[b][j*8 +: 8];
                        end
                    end
                end else begin
                    bank_rdata[b] <= mem[b][bank_row[b]];
                end
            end
        end
    end

    // Advance each bank's pointer past the port it just granted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < int'(NumBanks); b++) begin
                rr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < int'(NumBanks); b++) begin
                if (win_any[b]) begin
                    rr_ptr[b] <= PortW'((int'(win_port[b]) + 1) % int'(NumPorts));
                end
            end
        end
    end

    // Load the first response stage for every granted request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_vld <= '0;
            s0_err <= '0;
            s0_rd  <= '0;
            for (int p = 0; p < int'(NumPorts); p++) begin
                s0_bank[p] <= '0;
            end
        end else begin
            for (int p = 0; p < int'(NumPorts); p++) begin
                s0_vld[p]  <= gnt_o[p] && (!port_inr[p] || wen_i[p] || WriteResp);
                s0_err[p]  <= gnt_o[p] && !port_inr[p];
                s0_rd[p]   <= gnt_o[p] && port_inr[p] && wen_i[p];
                s0_bank[p] <= port_bank[p];
            end
        end
    end

    // Pick the bank read register for reads; writes and errors return zero
    always_comb begin
        for (int p = 0; p < int'(NumPorts); p++) begin
            st0_data[p] = (s0_vld[p] && s0_rd[p]) ? bank_rdata[s0_bank[p]] : '0;
        end
    end

    generate
        if (MemLatency == 1) begin : g_lat1
            assign vld_o = s0_vld;
            assign err_o = s0_err;
            for (genvar p = 0; p < NumPorts; p++) begin : g_rdata
                assign rdata_o[p*DataWidth +: DataWidth] = st0_data[p];
            end
        end else begin : g_latn
            logic [NumPorts-1:0]  t_vld  [MemLatency-1];
            logic [NumPorts-1:0]  t_err  [MemLatency-1];
            logic [DataWidth-1:0] t_data [MemLatency-1][NumPorts];

            // Delay the response by the extra MemLatency-1 register stages
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int k = 0; k < int'(MemLatency) - 1; k++) begin
                        t_vld[k] <= '0;
                        t_err[k] <= '0;
                        for (int p = 0; p < int'(NumPorts); p++) begin
                            t_data[k][p] <= '0;
                        end
                    end
                end else begin
                    t_vld[0] <= s0_vld;
                    t_err[0] <= s0_err;
                    for (int p = 0; p < int'(NumPorts); p++) begin
                        t_data[0][p] <= st0_data[p];
                    end
                    for (int k = 1; k < int'(MemLatency) - 1; k++) begin
                        t_vld[k] <= t_vld[k-1];
                        t_err[k] <= t_err[k-1];
                        for (int p = 0; p < int'(NumPorts); p++) begin
                            t_data[k][p] <= t_data[k-1][p];
                        end
                    end
                end
            end

            assign vld_o = t_vld[MemLatency-2];
            assign err_o = t_err[MemLatency-2];
            for (genvar p = 0; p < NumPorts; p++) begin : g_rdata
                assign rdata_o[p*DataWidth +: DataWidth] = t_data[MemLatency-2][p];
            end
        end
    endgenerate

    // Count in-range requesters that lost arbitration this cycle
    always_comb begin
        lose_cnt = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            lose_cnt = lose_cnt + CntW'(lose_vec[p]);
        end
        cnt_sum = {1'b0, conflict_cnt_o} + 33'(lose_cnt);
    end

    // Saturating conflict counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_cnt_o <= '0;
        end else begin
            conflict_cnt_o <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        end
    end

endmodule

// File: tb/tb_l3_banked_tcdm_mem.sv
// Directed bench for l3_banked_tcdm_mem: one default instance (latency 1, write
// responses on) and one with MemLatency=3, WriteResp=0.
module tb_l3_banked_tcdm_mem;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = 4;

    // Clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: default parameters
    logic           a_rst;
    logic [NP-1:0]  a_req, a_wen, a_gnt, a_vld, a_err;
    logic [NP*AW-1:0] a_add;
    logic [NP*DW-1:0] a_wdata, a_rdata;
    logic [NP*BW-1:0] a_be;
    logic [31:0]    a_cnt;

    // Instance b: MemLatency=3, WriteResp=0
    logic           b_rst;
    logic [NP-1:0]  b_req, b_wen, b_gnt, b_vld, b_err;
    logic [NP*AW-1:0] b_add;
    logic [NP*DW-1:0] b_wdata, b_rdata;
    logic [NP*BW-1:0] b_be;
    logic [31:0]    b_cnt;

    l3_banked_tcdm_mem dut_a (
        .clk_i(clk), .rst_i(a_rst), .req_i(a_req), .add_i(a_add), .wen_i(a_wen),
        .wdata_i(a_wdata), .be_i(a_be), .gnt_o(a_gnt), .vld_o(a_vld),
        .rdata_o(a_rdata), .err_o(a_err), .conflict_cnt_o(a_cnt)
    );

    l3_banked_tcdm_mem #(.MemLatency(3), .WriteResp(1'b0)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .req_i(b_req), .add_i(b_add), .wen_i(b_wen),
        .wdata_i(b_wdata), .be_i(b_be), .gnt_o(b_gnt), .vld_o(b_vld),
        .rdata_o(b_rdata), .err_o(b_err), .conflict_cnt_o(b_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard of read data still expected on instance b, port 2
    logic [DW-1:0] exp_q[$];

    logic [DW-1:0] conf_vals [4] = '{32'hC0DE_0000, 32'hC0DE_1111, 32'hC0DE_2222, 32'hC0DE_3333};
    logic [DW-1:0] lat_vals  [4] = '{32'h0102_0304, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666};

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input int p, input logic [AW-1:0] addr, input logic rd,
                           input logic [DW-1:0] data, input logic [BW-1:0] be);
        a_req[p] = 1'b1;
        a_add[p*AW +: AW] = addr;
        a_wen[p] = rd;
        a_wdata[p*DW +: DW] = data;
        a_be[p*BW +: BW] = be;
    endtask

    task automatic b_drive(input int p, input logic [AW-1:0] addr, input logic rd,
                           input logic [DW-1:0] data, input logic [BW-1:0] be);
        b_req[p] = 1'b1;
        b_add[p*AW +: AW] = addr;
        b_wen[p] = rd;
        b_wdata[p*DW +: DW] = data;
        b_be[p*BW +: BW] = be;
    endtask

    function automatic logic [DW-1:0] a_rd(input int p);
        return a_rdata[p*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] b_rd(input int p);
        return b_rdata[p*DW +: DW];
    endfunction

    task automatic test_reset();
        repeat (2) tick();
        a_drive(0, 32'h8000_0000, 1'b1, '0, 4'hF);
        b_drive(0, 32'h8000_0000, 1'b1, '0, 4'hF);
        #1;
        n_total++; if (a_gnt !== 4'b0000) $display("FAIL rst_a_gnt: got %b want 0000", a_gnt); else n_pass++;
        n_total++; if (b_gnt !== 4'b0000) $display("FAIL rst_b_gnt: got %b want 0000", b_gnt); else n_pass++;
        n_total++; if (a_vld !== 4'b0000) $display("FAIL rst_a_vld: got %b want 0000", a_vld); else n_pass++;
        n_total++; if (a_err !== 4'b0000) $display("FAIL rst_a_err: got %b want 0000", a_err); else n_pass++;
        n_total++; if (a_rdata !== '0) $display("FAIL rst_a_rdata: got %h want 0", a_rdata); else n_pass++;
        n_total++; if (a_cnt !== 32'd0) $display("FAIL rst_a_cnt: got %0d want 0", a_cnt); else n_pass++;
        n_total++; if (b_vld !== 4'b0000) $display("FAIL rst_b_vld: got %b want 0000", b_vld); else n_pass++;
        n_total++; if (b_cnt !== 32'd0) $display("FAIL rst_b_cnt: got %0d want 0", b_cnt); else n_pass++;
        a_req = '0;
        b_req = '0;
        a_rst = 1'b0;
        b_rst = 1'b0;
        tick();
    endtask

    task automatic test_single_rw();
        a_drive(0, 32'h8000_0010, 1'b0, 32'hDEAD_BEEF, 4'hF);
        #1;
        n_total++; if (a_gnt !== 4'b0001) $display("FAIL single_wr_gnt: got %b want 0001", a_gnt); else n_pass++;
        tick();
        a_req = '0;
        n_total++; if (a_vld !== 4'b0001) $display("FAIL single_wr_vld: got %b want 0001", a_vld); else n_pass++;
        n_total++; if (a_rd(0) !== 32'h0) $display("FAIL single_wr_rdata: got %h want 0", a_rd(0)); else n_pass++;
        a_drive(0, 32'h8000_0010, 1'b1, '0, 4'h0);
        #1;
        n_total++; if (a_gnt !== 4'b0001) $display("FAIL single_rd_gnt: got %b want 0001", a_gnt); else n_pass++;
        tick();
        a_req = '0;
        n_total++; if (a_vld !== 4'b0001) $display("FAIL single_rd_vld: got %b want 0001", a_vld); else n_pass++;
        n_total++; if (a_err !== 4'b0000) $display("FAIL single_rd_err: got %b want 0000", a_err); else n_pass++;
        n_total++; if (a_rd(0) !== 32'hDEAD_BEEF) $display("FAIL single_rd_data: got %h want deadbeef", a_rd(0)); else n_pass++;
        tick();
        n_total++; if (a_vld !== 4'b0000) $display("FAIL single_idle_vld: got %b want 0000", a_vld); else n_pass++;
    endtask

    task automatic test_byte_enable();
        a_drive(0, 32'h8000_0004, 1'b0, 32'h1122_3344, 4'hF);
        tick();
        a_drive(0, 32'h8000_0004, 1'b0, 32'hAABB_CCDD, 4'b0101);
        #1;
        n_total++; if (a_gnt !== 4'b0001) $display("FAIL be_wr_gnt: got %b want 0001", a_gnt); else n_pass++;
        tick();
        a_drive(0, 32'h8000_0004, 1'b1, '0, 4'h0);
        tick();
        a_req = '0;
        n_total++; if (a_vld !== 4'b0001) $display("FAIL be_rd_vld: got %b want 0001", a_vld); else n_pass++;
        n_total++; if (a_rd(0) !== 32'h11BB_33DD) $display("FAIL be_rd_data: got %h want 11bb33dd", a_rd(0)); else n_pass++;
    endtask

    task automatic test_conflict();
        logic [NP-1:0] e;
        // Seed bank 2 through port 3 so that bank's pointer wraps back to port 0
        for (int i = 0; i < 4; i++) begin
            a_drive(3, 32'h8000_0008 + 32'(i * 16), 1'b0, conf_vals[i], 4'hF);
            tick();
        end
        a_req = '0;
        a_drive(0, 32'h8000_000C, 1'b0, 32'h0BAD_F00D, 4'hF);
        tick();
        a_req = '0;
        n_total++; if (a_cnt !== 32'd0) $display("FAIL conf_cnt_start: got %0d want 0", a_cnt); else n_pass++;
        for (int p = 0; p < 4; p++) begin
            a_drive(p, 32'h8000_0008 + 32'(p * 16), 1'b1, '0, 4'h0);
        end
        for (int c = 0; c < 4; c++) begin
            e = 4'(1 << c);
            #1;
            n_total++; if (a_gnt !== e) $display("FAIL conf_gnt_%0d: got %b want %b", c, a_gnt, e); else n_pass++;
            tick();
            a_req[c] = 1'b0;
            n_total++; if (a_vld !== e) $display("FAIL conf_vld_%0d: got %b want %b", c, a_vld, e); else n_pass++;
            n_total++; if (a_rd(c) !== conf_vals[c]) $display("FAIL conf_data_%0d: got %h want %h", c, a_rd(c), conf_vals[c]); else n_pass++;
        end
        n_total++; if (a_cnt !== 32'd6) $display("FAIL conf_cnt_end: got %0d want 6", a_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_parallel();
        a_drive(0, 32'h8000_0010, 1'b1, '0, 4'h0);
        a_drive(1, 32'h8000_0004, 1'b1, '0, 4'h0);
        a_drive(2, 32'h8000_0008, 1'b1, '0, 4'h0);
        a_drive(3, 32'h8000_000C, 1'b1, '0, 4'h0);
        #1;
        n_total++; if (a_gnt !== 4'b1111) $display("FAIL par_gnt: got %b want 1111", a_gnt); else n_pass++;
        tick();
        a_req = '0;
        n_total++; if (a_vld !== 4'b1111) $display("FAIL par_vld: got %b want 1111", a_vld); else n_pass++;
        n_total++; if (a_rd(0) !== 32'hDEAD_BEEF) $display("FAIL par_data0: got %h want deadbeef", a_rd(0)); else n_pass++;
        n_total++; if (a_rd(1) !== 32'h11BB_33DD) $display("FAIL par_data1: got %h want 11bb33dd", a_rd(1)); else n_pass++;
        n_total++; if (a_rd(2) !== 32'hC0DE_0000) $display("FAIL par_data2: got %h want c0de0000", a_rd(2)); else n_pass++;
        n_total++; if (a_rd(3) !== 32'h0BAD_F00D) $display("FAIL par_data3: got %h want 0badf00d", a_rd(3)); else n_pass++;
        n_total++; if (a_cnt !== 32'd6) $display("FAIL par_cnt: got %0d want 6", a_cnt); else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [AW-1:0] oor_addr [3];
        logic          oor_rd   [3];
        oor_addr = '{32'h7FFF_FFFC, 32'h8000_4000, 32'h8000_4000};
        oor_rd   = '{1'b0, 1'b0, 1'b1};
        a_drive(0, 32'h8000_0000, 1'b0, 32'h5A5A_5A5A, 4'hF);
        tick();
        a_req = '0;
        for (int i = 0; i < 3; i++) begin
            a_drive(1, oor_addr[i], oor_rd[i], 32'hFFFF_FFFF, 4'hF);
            #1;
            n_total++; if (a_gnt !== 4'b0010) $display("FAIL oor_gnt_%0d: got %b want 0010", i, a_gnt); else n_pass++;
            tick();
            a_req = '0;
            n_total++; if (a_vld !== 4'b0010) $display("FAIL oor_vld_%0d: got %b want 0010", i, a_vld); else n_pass++;
            n_total++; if (a_err !== 4'b0010) $display("FAIL oor_err_%0d: got %b want 0010", i, a_err); else n_pass++;
            n_total++; if (a_rd(1) !== 32'h0) $display("FAIL oor_rdata_%0d: got %h want 0", i, a_rd(1)); else n_pass++;
        end
        a_drive(1, 32'h8000_0000, 1'b1, '0, 4'h0);
        tick();
        a_req = '0;
        n_total++; if (a_err !== 4'b0000) $display("FAIL oor_chk_err: got %b want 0000", a_err); else n_pass++;
        n_total++; if (a_rd(1) !== 32'h5A5A_5A5A) $display("FAIL oor_chk_data: got %h want 5a5a5a5a", a_rd(1)); else n_pass++;
        n_total++; if (a_cnt !== 32'd6) $display("FAIL oor_cnt: got %0d want 6", a_cnt); else n_pass++;
    endtask

    task automatic test_latency_sweep();
        logic [DW-1:0] e;
        for (int k = 0; k < 4; k++) begin
            b_drive(2, 32'h8000_0000 + 32'(k * 4), 1'b0, lat_vals[k], 4'hF);
            #1;
            n_total++; if (b_gnt !== 4'b0100) $display("FAIL lat_wr_gnt_%0d: got %b want 0100", k, b_gnt); else n_pass++;
            tick();
            n_total++; if (b_vld !== 4'b0000) $display("FAIL lat_wr_vld_%0d: got %b want 0000", k, b_vld); else n_pass++;
        end
        b_req = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++; if (b_vld !== 4'b0000) $display("FAIL lat_wr_tail_%0d: got %b want 0000", k, b_vld); else n_pass++;
        end
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                b_drive(2, 32'h8000_0000 + 32'(k * 4), 1'b1, '0, 4'h0);
                exp_q.push_back(lat_vals[k]);
                #1;
                n_total++; if (b_gnt !== 4'b0100) $display("FAIL lat_rd_gnt_%0d: got %b want 0100", k, b_gnt); else n_pass++;
            end else begin
                b_req = '0;
            end
            tick();
            if (k >= 2 && k <= 5) begin
                e = exp_q.pop_front();
                n_total++; if (b_vld !== 4'b0100) $display("FAIL lat_rd_vld_%0d: got %b want 0100", k, b_vld); else n_pass++;
                n_total++; if (b_rd(2) !== e) $display("FAIL lat_rd_data_%0d: got %h want %h", k, b_rd(2), e); else n_pass++;
            end else begin
                n_total++; if (b_vld !== 4'b0000) $display("FAIL lat_rd_novld_%0d: got %b want 0000", k, b_vld); else n_pass++;
            end
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL lat_queue_left: got %0d want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        b_drive(0, 32'h8000_0000, 1'b1, '0, 4'h0);
        b_drive(1, 32'h8000_0000, 1'b1, '0, 4'h0);
        b_drive(2, 32'h8000_0004, 1'b1, '0, 4'h0);
        #1;
        n_total++; if (b_gnt[2] !== 1'b1) $display("FAIL rmid_gnt2: got %b want 1", b_gnt[2]); else n_pass++;
        n_total++; if ((b_gnt[0] ^ b_gnt[1]) !== 1'b1) $display("FAIL rmid_gnt01: got %b want one of two", b_gnt[1:0]); else n_pass++;
        tick();
        b_req = '0;
        n_total++; if (b_cnt !== 32'd1) $display("FAIL rmid_cnt_pre: got %0d want 1", b_cnt); else n_pass++;
        b_rst = 1'b1;
        b_drive(3, 32'h8000_0000, 1'b1, '0, 4'h0);
        #1;
        n_total++; if (b_gnt !== 4'b0000) $display("FAIL rmid_gnt_rst: got %b want 0000", b_gnt); else n_pass++;
        tick();
        b_req = '0;
        b_rst = 1'b0;
        n_total++; if (b_vld !== 4'b0000) $display("FAIL rmid_vld_rst: got %b want 0000", b_vld); else n_pass++;
        n_total++; if (b_cnt !== 32'd0) $display("FAIL rmid_cnt_rst: got %0d want 0", b_cnt); else n_pass++;
        n_total++; if (b_rdata !== '0) $display("FAIL rmid_rdata_rst: got %h want 0", b_rdata); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++; if (b_vld !== 4'b0000) $display("FAIL rmid_dropped_%0d: got %b want 0000", k, b_vld); else n_pass++;
        end
        b_drive(2, 32'h8000_0004, 1'b1, '0, 4'h0);
        #1;
        n_total++; if (b_gnt !== 4'b0100) $display("FAIL rmid_post_gnt: got %b want 0100", b_gnt); else n_pass++;
        tick();
        b_req = '0;
        for (int k = 0; k < 2; k++) begin
            n_total++; if (b_vld !== 4'b0000) $display("FAIL rmid_post_early_%0d: got %b want 0000", k, b_vld); else n_pass++;
            tick();
        end
        n_total++; if (b_vld !== 4'b0100) $display("FAIL rmid_post_vld: got %b want 0100", b_vld); else n_pass++;
        n_total++; if (b_rd(2) !== lat_vals[1]) $display("FAIL rmid_post_data: got %h want %h", b_rd(2), lat_vals[1]); else n_pass++;
    endtask

    // Reset, scenario sequence and final report
    initial begin
        a_rst = 1'b1; a_req = '0; a_add = '0; a_wen = '0; a_wdata = '0; a_be = '0;
        b_rst = 1'b1; b_req = '0; b_add = '0; b_wen = '0; b_wdata = '0; b_be = '0;
        test_reset();
        test_single_rw();
        test_byte_enable();
        test_conflict();
        test_parallel();
        test_out_of_range();
        test_latency_sweep();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
